// File: rtl/request_agent_pkg.sv
// Shared constants and state encoding for the request agent and its service timer.
package request_agent_pkg;

    localparam int NUM_PORTS   = 8;
    localparam int CNT_W       = 4;
    localparam int SVC_LEN_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/request_agent_svc_timer.sv
// Loadable down-counter that times one grant's service window; holds at zero.
module svc_timer
    import request_agent_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/request_agent.sv
// Collects per-port request strobes, presents them to an external arbiter and
// services one granted port at a time for SVC_LEN cycles.
module request_agent
    import request_agent_pkg::*;
#(
    parameter int SVC_LEN = SVC_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_pulse,
    input  logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] req,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] served,
    output logic                 overflow,
    output logic                 grant_err
);

    localparam logic [CNT_W-1:0] SVC_LOAD = CNT_W'(SVC_LEN - 1);

    state_e               state;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] active;
    logic [NUM_PORTS-1:0] clr_mask;
    logic                 g_onehot;
    logic                 g_ok;
    logic                 done;
    logic                 tmr_zero;
    logic                 tmr_load;
    logic                 tmr_en;

    always_comb begin
        g_onehot = (grant != '0) && ((grant & (grant - NUM_PORTS'(1))) == '0);
        g_ok     = g_onehot && ((grant & pending) != '0);
        done     = (state == BUSY) && tmr_zero;
        clr_mask = done ? active : '0;
        tmr_load = (state == IDLE) && g_ok;
        tmr_en   = (state == BUSY);
    end

    svc_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (SVC_LOAD),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            active    <= '0;
            served    <= '0;
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            // A strobe landing on the port being cleared re-arms it rather than merging.
            pending   <= (pending & ~clr_mask) | req_pulse;
            overflow  <= |(req_pulse & pending & ~clr_mask);
            served    <= '0;
            grant_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (g_ok) begin
                        state  <= BUSY;
                        active <= grant;
                    end else if (grant != '0) begin
                        grant_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (tmr_zero) begin
                        state  <= IDLE;
                        served <= active;
                        active <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req  = (state == IDLE) ? pending : '0;
    assign busy = (state == BUSY);

endmodule

// File: tb/tb_request_agent.sv
// Directed bench for request_agent with a fixed-priority arbiter in the loop and
// a scoreboard of expected output pulses (served / overflow / grant_err).
module tb_request_agent;

    localparam logic [1:0] K_SERVED = 2'd0;
    localparam logic [1:0] K_OVF    = 2'd1;
    localparam logic [1:0] K_GERR   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_pulse = 8'h00;
    logic [7:0] grant;
    logic [7:0] req;
    logic       busy;
    logic [7:0] served;
    logic       overflow;
    logic       grant_err;

    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;

    int   total = 0;
    int   bad = 0;
    evt_t exp_q[$];

    always #5 clk = ~clk;

    // Fixed-priority arbiter: lowest-index pending port wins.
    always_comb begin
        grant = req & (~req + 8'd1);
        if (force_en) grant = force_val;
    end

    request_agent #(.SVC_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .grant     (grant),
        .req       (req),
        .busy      (busy),
        .served    (served),
        .overflow  (overflow),
        .grant_err (grant_err)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [7:0] val);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [1:0] kind, input logic [7:0] val);
        evt_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_evt: kind %0d val %h with empty queue at %0t", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                bad++;
                $display("FAIL evt_order: got kind %0d val %h expected kind %0d val %h at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (served != 8'h00) observe(K_SERVED, served);
        if (overflow)        observe(K_OVF, 8'h00);
        if (grant_err)       observe(K_GERR, 8'h00);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_req", req, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_served", served, 8'h00);
        chk("rst_ovf_gerr", {6'd0, overflow, grant_err}, 8'h00);
        tick(2);
        rst_n = 1'b1;

        // Single request on port 3.
        push(K_SERVED, 8'h08);
        req_pulse = 8'h08;
        tick();                 // edge 1
        req_pulse = 8'h00;
        chk("single_req", req, 8'h08);
        chk("single_idle", {7'd0, busy}, 8'h00);
        tick();                 // edge 2
        chk("single_busy2", {7'd0, busy}, 8'h01);
        chk("single_req_busy", req, 8'h00);
        tick(3);                // edge 5
        chk("single_busy5", {7'd0, busy}, 8'h01);
        chk("single_served5", served, 8'h00);
        tick();                 // edge 6
        chk("single_served", served, 8'h08);
        chk("single_done", {7'd0, busy}, 8'h00);
        chk("single_req_after", req, 8'h00);
        tick();
        chk("single_pulse_len", served, 8'h00);

        // Priority: ports 0 and 3 together.
        push(K_SERVED, 8'h01);
        push(K_SERVED, 8'h08);
        req_pulse = 8'h09;
        tick();                 // edge 1
        req_pulse = 8'h00;
        chk("prio_req", req, 8'h09);
        tick(5);                // edge 6
        chk("prio_first", served, 8'h01);
        chk("prio_gap_req", req, 8'h08);
        chk("prio_gap_idle", {7'd0, busy}, 8'h00);
        tick(4);                // edge 10
        chk("prio_not_yet", served, 8'h00);
        tick();                 // edge 11
        chk("prio_second", served, 8'h08);
        tick(2);

        // Merge / overflow with the arbiter held off.
        force_en  = 1'b1;
        force_val = 8'h00;
        req_pulse = 8'h04;
        tick();
        req_pulse = 8'h00;
        tick();
        push(K_OVF, 8'h00);
        req_pulse = 8'h04;
        tick();
        req_pulse = 8'h00;
        chk("merge_ovf", {7'd0, overflow}, 8'h01);
        chk("merge_req", req, 8'h04);
        tick();
        chk("merge_ovf_once", {7'd0, overflow}, 8'h00);
        push(K_SERVED, 8'h04);
        force_en = 1'b0;
        tick(6);
        chk("merge_drained", req, 8'h00);

        // Collision: port 1 re-strobed during its last BUSY cycle.
        push(K_SERVED, 8'h02);
        push(K_SERVED, 8'h02);
        req_pulse = 8'h02;
        tick();                 // edge 1
        req_pulse = 8'h00;
        tick(4);                // edge 5: final BUSY cycle
        chk("coll_busy", {7'd0, busy}, 8'h01);
        req_pulse = 8'h02;
        tick();                 // edge 6
        req_pulse = 8'h00;
        chk("coll_served", served, 8'h02);
        chk("coll_kept", req, 8'h02);
        chk("coll_no_ovf", {7'd0, overflow}, 8'h00);
        tick();                 // edge 7
        chk("coll_regrant", {7'd0, busy}, 8'h01);
        tick(5);

        // Malformed grants in IDLE.
        force_en  = 1'b1;
        force_val = 8'h00;
        req_pulse = 8'h01;
        tick();
        req_pulse = 8'h00;
        push(K_GERR, 8'h00);
        force_val = 8'h03;
        tick();
        chk("bad_multi_err", {7'd0, grant_err}, 8'h01);
        chk("bad_multi_idle", {7'd0, busy}, 8'h00);
        push(K_GERR, 8'h00);
        force_val = 8'h10;
        tick();
        chk("bad_subset_err", {7'd0, grant_err}, 8'h01);
        chk("bad_subset_idle", {7'd0, busy}, 8'h00);
        force_val = 8'h00;
        tick();
        chk("bad_err_clear", {7'd0, grant_err}, 8'h00);
        chk("bad_pending", req, 8'h01);
        push(K_SERVED, 8'h01);
        force_en = 1'b0;
        tick(7);

        // Reset in the middle of a service.
        req_pulse = 8'h21;
        tick();                 // edge 1
        req_pulse = 8'h00;
        tick(2);                // edge 3: second BUSY cycle
        chk("rst_pre_busy", {7'd0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", req, 8'h00);
        chk("rst_mid_busy", {7'd0, busy}, 8'h00);
        chk("rst_mid_served", served, 8'h00);
        chk("rst_mid_flags", {6'd0, overflow, grant_err}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("rst_dropped", req, 8'h00);
        tick(8);
        chk("rst_stays_idle", {7'd0, busy}, 8'h00);

        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/request_agent.md
REQUEST_AGENT -- requirements
Module: request_agent

Interface
REQ-001 Parameter SVC_LEN, default 4, meaning service duration in cycles per grant; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_pulse  input  8  per-port single-cycle request strobes; bit i = port i.
REQ-005 grant  input  8  grant vector from the 8-port fixed-priority arbiter; expected one-hot or zero; combinational function of req.
REQ-006 req  output  8  pending-request vector driven to the arbiter.
REQ-007 busy  output  1  high while a granted port is being serviced.
REQ-008 served  output  8  one-hot, one-cycle pulse naming the port whose service just completed.
REQ-009 overflow  output  1  one-cycle pulse: a request strobe hit an already-pending port and was merged.
REQ-010 grant_err  output  1  one-cycle pulse: malformed grant seen in IDLE.

Function
REQ-011 pending[7:0] register SHALL set bit i on req_pulse[i] at each rising edge, in any state.
REQ-012 req SHALL equal pending in IDLE and 8'h00 in BUSY.
REQ-013 FSM SHALL have two states, IDLE and BUSY, encoded 1'b0/1'b1.
REQ-014 IDLE -> BUSY SHALL occur when grant is non-zero, one-hot, and grant & pending != 0; active <= grant, cnt <= SVC_LEN-1.
REQ-015 In IDLE, a non-zero grant that is not one-hot or not a subset of pending SHALL be ignored (no state change), with grant_err pulsed the next cycle.
REQ-016 In BUSY, cnt SHALL decrement by 1 per cycle; BUSY SHALL last exactly SVC_LEN cycles.
REQ-017 BUSY with cnt == 0 -> IDLE at the next edge; at that edge pending &= ~active, served <= active for one cycle, active <= 0.
REQ-018 A req_pulse on the active port in the same cycle as its clear SHALL win: the bit stays pending.
REQ-019 overflow SHALL pulse the cycle after req_pulse[i] arrives while pending[i] is already 1 and not being cleared that edge.
REQ-020 busy SHALL equal (state == BUSY).
REQ-021 Latency: strobe at edge k -> req bit high after edge k; a valid grant in that cycle -> BUSY after edge k+1; served pulse after edge k+1+SVC_LEN.
REQ-022 cnt is 4 bits unsigned; no wrap below 0: it is reloaded only on IDLE -> BUSY.
REQ-023 Grant input in BUSY SHALL be ignored.

Reset
REQ-024 While rst_n = 0: state = IDLE, pending = 0, active = 0, cnt = 0, req = 0, busy = 0, served = 0, overflow = 0, grant_err = 0.
REQ-025 Reset asserted mid-service SHALL abort it: no served pulse, all pending requests dropped.
REQ-026 First state update SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package/include SHALL hold: port count 8, state encodings IDLE/BUSY, SVC_LEN default, cnt width 4.
REQ-028 One sub-module, svc_timer: loadable 4-bit down-counter with load, enable, and zero flag; instantiated once.
REQ-029 One-hot check SHALL be (g != 0) && ((g & (g-1)) == 0), inline.
REQ-030 All outputs SHALL be registered except req and busy, which are decoded from registers only.

Verification (SVC_LEN = 4, bench instantiates the fixed-priority arbiter on req -> grant)
REQ-031 Single: req_pulse = 8'h08 at edge 1 -> req = 8'h08, busy high cycles 2..5, served = 8'h08 for one cycle after edge 6, req = 0.
REQ-032 Priority: req_pulse = 8'h09 -> served 8'h01 first, then 8'h08 exactly 5 cycles later; req = 8'h08 during the IDLE cycle between services.
REQ-033 Merge/overflow: req_pulse = 8'h04 twice, 2 cycles apart, with grant forced to 0 -> single pending bit, overflow pulses once.
REQ-034 Collision: req_pulse = 8'h02 in the final BUSY cycle of port 1 -> served = 8'h02 and port 1 re-granted on the next IDLE cycle.
REQ-035 Bad grant: grant forced to 8'h03, then to 8'h10 with pending = 8'h01 -> grant_err pulses each time, state stays IDLE.
REQ-036 Reset: rst_n low at BUSY cycle 2 with pending = 8'h21 -> all outputs 0 immediately, no served pulse after release.
